// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
// The grantee writes every cycle it keeps its request up; a hold counter bounds tenure under contention.
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [WIDTH-1:0]       q_o,
    output logic                   q_valid_o,
    output logic [IDX_W-1:0]       owner_o,
    output logic                   busy_o
);
    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                        state;
    logic [IDX_W-1:0]              ptr;
    logic [IDX_W-1:0]              cur;
    logic [HOLD_W-1:0]             hold;
    logic [N_REQ-1:0][WIDTH-1:0]   data_arr;

    logic                          wr;
    logic                          others;
    logic                          tenure_end;
    logic [N_REQ-1:0]              cur_oh;
    logic [N_REQ-1:0]              cand;
    logic [IDX_W-1:0]              cur_next;
    logic [IDX_W-1:0]              search_base;
    logic [IDX_W-1:0]              scan_idx;
    logic [IDX_W-1:0]              pick_idx;
    logic                          pick_vld;

    assign data_arr = data_i;
    assign busy_o   = |gnt_o;

    always_comb begin
        cur_oh      = N_REQ'(1) << cur;
        cur_next    = (cur == IDX_W'(N_REQ - 1)) ? '0 : cur + 1'b1;
        wr          = (state == GRANT) && req_i[cur];
        others      = |(req_i & ~cur_oh);
        tenure_end  = (state == GRANT) &&
                      (!req_i[cur] || (wr && (hold == HOLD_LAST) && others));
        // While granted, the current owner is masked out and the scan starts just past it.
        cand        = (state == GRANT) ? (req_i & ~cur_oh) : req_i;
        search_base = (state == GRANT) ? cur_next : ptr;
        pick_vld    = 1'b0;
        pick_idx    = '0;
        scan_idx    = '0;
        // Scan from the far end back so the nearest pending requester wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_idx = IDX_W'((int'(search_base) + i) % N_REQ);
            if (cand[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt_o     <= '0;
            cur       <= '0;
            ptr       <= '0;
            hold      <= '0;
            q_o       <= '0;
            q_valid_o <= 1'b0;
            owner_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= GRANT;
                        cur   <= pick_idx;
                        gnt_o <= N_REQ'(1) << pick_idx;
                        hold  <= '0;
                    end
                end
                GRANT: begin
                    if (wr) begin
                        q_o       <= data_arr[cur];
                        owner_o   <= cur;
                        q_valid_o <= 1'b1;
                    end
                    if (tenure_end) begin
                        ptr  <= cur_next;
                        hold <= '0;
                        if (pick_vld) begin
                            cur   <= pick_idx;
                            gnt_o <= N_REQ'(1) << pick_idx;
                        end else begin
                            state <= IDLE;
                            gnt_o <= '0;
                        end
                    end else if (wr && (hold != HOLD_LAST)) begin
                        // Saturates for a lone requester so expiry fires as soon as contention appears.
                        hold <= hold + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: stimulus queues expected post-edge state,
// a negedge monitor pops and compares when the tagged cycle comes up.
module tb_shared_reg_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [1:0]  owner;
    logic        busy;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic        qv;
        logic [1:0]  own;
    } exp_t;
    exp_t exp_q[$];

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req_i(req), .data_i(data),
        .gnt_o(gnt), .q_o(q), .q_valid_o(qv), .owner_o(owner), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive inputs for this cycle and queue the state expected after the next edge.
    task automatic st(input logic [3:0] r, input logic [31:0] d, input logic [3:0] eg,
                      input logic [7:0] eq, input logic eqv, input logic [1:0] eo);
        exp_t e;
        req  = r;
        data = d;
        e.cyc = cyc + 1; e.gnt = eg; e.q = eq; e.qv = eqv; e.own = eo;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("gnt",   32'(gnt),   32'(e.gnt));
                chk("q",     32'(q),     32'(e.q));
                chk("qv",    32'(qv),    32'(e.qv));
                chk("owner", 32'(owner), 32'(e.own));
                chk("busy",  32'(busy),  32'(|e.gnt));
            end else if (exp_q[0].cyc < cyc) begin
                chk("sb_missed", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),   0);
        chk({tag, "_q"},     32'(q),     0);
        chk({tag, "_qv"},    32'(qv),    0);
        chk({tag, "_owner"}, 32'(owner), 0);
        chk({tag, "_busy"},  32'(busy),  0);
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b1111;
        data  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");

        // Reset release and first write of A5 by requester 0
        reset = 1'b1;
        st(4'b0001, 32'h0000_00A5, 4'b0001, 8'h00, 1'b0, 2'd0);
        st(4'b0001, 32'h0000_00A5, 4'b0001, 8'hA5, 1'b1, 2'd0);

        // Full contention: requester 0 finishes its 4 writes, then 1, 2, 3, 0
        st(4'b1111, 32'h1312_1110, 4'b0001, 8'h10, 1'b1, 2'd0);
        st(4'b1111, 32'h1312_1110, 4'b0001, 8'h10, 1'b1, 2'd0);
        st(4'b1111, 32'h1312_1110, 4'b0010, 8'h10, 1'b1, 2'd0);
        for (int k = 1; k < 4; k++) begin
            logic [7:0] dk;
            logic [3:0] gk;
            logic [3:0] gn;
            dk = 8'h10 + 8'(k);
            gk = 4'b0001 << k;
            gn = (k == 3) ? 4'b0001 : (4'b0001 << (k + 1));
            for (int w = 0; w < 3; w++)
                st(4'b1111, 32'h1312_1110, gk, dk, 1'b1, 2'(k));
            st(4'b1111, 32'h1312_1110, gn, dk, 1'b1, 2'(k));
        end
        st(4'b1111, 32'h1312_1110, 4'b0001, 8'h10, 1'b1, 2'd0);

        // Early release: requester 0 drops, requester 2 takes over with no bubble
        st(4'b0101, 32'h00C2_00A0, 4'b0001, 8'hA0, 1'b1, 2'd0);
        st(4'b0100, 32'h00C2_00A0, 4'b0100, 8'hA0, 1'b1, 2'd0);
        st(4'b0100, 32'h00C2_00A0, 4'b0100, 8'hC2, 1'b1, 2'd2);
        st(4'b0100, 32'h00C2_00A0, 4'b0100, 8'hC2, 1'b1, 2'd2);

        // Asynchronous reset just after a falling edge, checked before the next rising edge
        @(negedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b0000;
        #1;
        chk_zero("arst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Pointer back at 0: requester 0 wins over 3
        st(4'b1001, 32'hD300_00D0, 4'b0001, 8'h00, 1'b0, 2'd0);
        st(4'b1001, 32'hD300_00D0, 4'b0001, 8'hD0, 1'b1, 2'd0);
        st(4'b1000, 32'hD300_00D0, 4'b1000, 8'hD0, 1'b1, 2'd0);
        st(4'b1000, 32'hD300_00D0, 4'b1000, 8'hD3, 1'b1, 2'd3);

        // Pointer wrap after requester 3: order 0, 1, 3
        st(4'b0011, 32'hE3E2_E1E0, 4'b0001, 8'hD3, 1'b1, 2'd3);
        st(4'b1011, 32'hE3E2_E1E0, 4'b0001, 8'hE0, 1'b1, 2'd0);
        st(4'b1010, 32'hE3E2_E1E0, 4'b0010, 8'hE0, 1'b1, 2'd0);
        st(4'b1010, 32'hE3E2_E1E0, 4'b0010, 8'hE1, 1'b1, 2'd1);
        st(4'b1000, 32'hE3E2_E1E0, 4'b1000, 8'hE1, 1'b1, 2'd1);
        st(4'b1000, 32'hE3E2_E1E0, 4'b1000, 8'hE3, 1'b1, 2'd3);
        st(4'b0000, 32'hE3E2_E1E0, 4'b0000, 8'hE3, 1'b1, 2'd3);

        // Sole requester 1 with incrementing data, grant never expires
        st(4'b0010, 32'h0000_0100, 4'b0010, 8'hE3, 1'b1, 2'd3);
        for (int i = 1; i <= 10; i++)
            st(4'b0010, {16'h0, 8'(i), 8'h00}, 4'b0010, 8'(i), 1'b1, 2'd1);

        // Saturated hold: contention expires the tenure on the very next write
        st(4'b0011, 32'h0000_0B5A, 4'b0001, 8'h0B, 1'b1, 2'd1);
        st(4'b0011, 32'h0000_0B5A, 4'b0001, 8'h5A, 1'b1, 2'd0);
        // Release and new requests together: round-robin from 1 picks 1
        st(4'b0110, 32'h0000_0B5A, 4'b0010, 8'h5A, 1'b1, 2'd0);
        st(4'b0000, 32'h0000_0B5A, 4'b0000, 8'h5A, 1'b1, 2'd0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register between N_REQ requesters. Each requester raises a request and presents data; the arbiter grants one requester at a time, and the shared register captures the granted requester's data on every clock edge. A hold counter caps how long a requester can keep the grant under contention. The block sits between independent producers and a single stored value that downstream logic reads.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- MAX_HOLD, 4, maximum consecutive write cycles per tenure while others are pending (>=1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_i  input  N_REQ  request per requester, level-sensitive
- data_i  input  N_REQ*WIDTH  requester k data at bits [k*WIDTH +: WIDTH]
- gnt_o  output  N_REQ  registered one-hot grant (all-zero when idle)
- q_o  output  WIDTH  shared register contents
- q_valid_o  output  1  high once any write has occurred since reset
- owner_o  output  clog2(N_REQ)  index of the requester that last wrote q_o
- busy_o  output  1  high while any gnt_o bit is set

## Operation
- Reset (reset=0, asynchronous): gnt_o=0, q_o=0, q_valid_o=0, owner_o=0, busy_o=0, hold count=0, RR pointer=0, state IDLE.
- Two-state FSM:
  - IDLE: if req_i != 0, go to GRANT with gnt_o = first requester with a set request, searching from the pointer upward mod N_REQ.
  - GRANT (grantee k):
    - Write: in any cycle with gnt_o[k]=1 and req_i[k]=1, the next edge loads q_o <= data_i slice k. The same edge sets owner_o=k and q_valid_o=1, and increments the hold count.
    - If gnt_o[k]=1 and req_i[k]=0, there is no write that cycle.
- End of tenure, evaluated each GRANT cycle:
  - Release: req_i[k]=0.
  - Expiry: a write occurs with hold count == MAX_HOLD-1, and some req_i[j]=1 with j!=k.
- On end of tenure:
  - Pointer <= k+1 mod N_REQ.
  - Hold count <= 0.
  - Next grant = first pending requester j!=k, searching from k+1. If none is pending, gnt_o=0 and the FSM returns to IDLE.
- No contention: if the grantee is the only requester, expiry is suppressed, the grant persists indefinitely, and the hold count saturates at MAX_HOLD-1.
- gnt_o is never multi-hot. busy_o = |gnt_o.

## Timing
- Request at cycle t (idle arbiter): gnt_o is high in cycle t+1, and q_o shows the data in cycle t+2. Request-to-q_o latency is 2 cycles.
- Handoff has no bubble. If the grantee's request drops in cycle t and another requester is pending, the new gnt_o is visible in t+1.
- Under full contention each tenure gets exactly MAX_HOLD writes, and the grant changes on the edge of the last write.
- Simultaneous events:
  - A grantee release and a new request in the same cycle are decided by round-robin order, starting from k+1.
  - A new request from a higher-priority index never pre-empts the current tenure.
- data_i is sampled only for the granted requester, on the write edge. Other slices are don't-care.
- Asynchronous reset mid-tenure clears all outputs immediately, without waiting for a clock edge. Arbitration restarts from pointer 0 on the first edge after reset rises.

## Test plan
- Reset/basic:
  - Stimulus: hold reset=0 with req_i=4'b1111. Then release reset and drive req_i=4'b0001, data0=8'hA5.
  - Response: all outputs 0 during reset. gnt_o=4'b0001 one cycle after release, q_o=8'hA5 two cycles after, q_valid_o=1, owner_o=0.
- Full contention:
  - Stimulus: req_i=4'b1111 for 20 cycles, MAX_HOLD=4.
  - Response: grant order 0,1,2,3,0 with 4 writes each. gnt_o is always one-hot with no idle cycle. owner_o tracks the writer.
- Early release:
  - Stimulus: req0 held 2 cycles, then dropped, with req2 pending.
  - Response: gnt_o goes 0001->0100 on the next edge. q_o keeps data0 until data2 lands one cycle later.
- Sole requester:
  - Stimulus: req_i=4'b0010 held 10 cycles, data1 incrementing 1..10.
  - Response: gnt_o stays 0010 throughout, and q_o follows 1..10 with 1-cycle lag.
- Async reset mid-tenure:
  - Stimulus: assert reset at a falling edge while gnt_o=0100, then release it. Apply req_i=4'b1001.
  - Response: gnt_o, q_o, q_valid_o, busy_o are 0 before the next rising edge. After release the grant goes to requester 0 (pointer reset).
- Pointer wrap:
  - Stimulus: after requester 3's tenure ends, apply req_i=4'b1011.
  - Response: the next grant is requester 0, then 1, then 3.
